// File: rtl/axis_s.sv
// ---------------------------------------------------------------------------
// axis_s : AXI-Stream slave receiver with a first-word-fall-through buffer.
//
// Beats arriving on tvalid/tready/tdata/tlast are stored in a DEPTH-entry
// FIFO and presented to the user through rd_valid/rd_data/rd_last with a
// rd_en pop strobe. tready is registered and reflects buffer space only, so
// an accepted beat always has a slot and nothing is ever dropped.
//
// Optional feature macro: AXIS_S_STATUS_EN
//   defined   : beat_cnt / pkt_cnt count accepted beats / tlast beats.
//   undefined : both counters are constant zero and no registers are built.
// ---------------------------------------------------------------------------
module axis_s #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    // AXI-Stream receive channel
    input  logic                    tvalid,
    output logic                    tready,
    input  logic [DATA_WIDTH-1:0]   tdata,
    input  logic                    tlast,
    // User-side read interface
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    input  logic                    rd_en,
    // Status
    output logic [$clog2(DEPTH):0]  level,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    beat_cnt,
    output logic [CNT_WIDTH-1:0]    pkt_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + 1;

    // Level value meaning "no free slot"; full/empty come from the level,
    // never from comparing pointers, so the pointers can wrap freely.
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ZERO_LVL = {LVL_W{1'b0}};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ENT_W-1:0] mem_q [DEPTH];    // {tlast, tdata}; contents not reset

    logic [PTR_W-1:0] wptr_q,  wptr_d;
    logic [PTR_W-1:0] rptr_q,  rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             tready_q, tready_d;
    logic             done_q,   done_d;

    logic             push_s;
    logic             pop_s;
    logic             rd_valid_s;
    logic [ENT_W-1:0] head_s;

    // -----------------------------------------------------------------------
    // Handshake qualification
    // -----------------------------------------------------------------------
    // A pop on an empty buffer is meaningless and must not move anything, so
    // rd_en is qualified with the non-empty flag derived from the level.
    assign rd_valid_s = (level_q != ZERO_LVL);
    assign push_s     = tvalid & tready_q;
    assign pop_s      = rd_en & rd_valid_s;
    assign head_s     = mem_q[rptr_q];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // Compute pointer, level, tready and done next values from push/pop.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        tready_d = 1'b0;
        done_d   = 1'b0;

        if (push_s) begin
            wptr_d = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;   // idle, or push and pop cancel
        endcase

        // tready looks only at occupancy, never at tvalid, so the sender
        // sees a stable ready that cannot combinationally depend on it.
        tready_d = (level_d != FULL_LVL);
        done_d   = push_s & tlast;
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // Pointers, level, tready and done with asynchronous reset.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wptr_q   <= {PTR_W{1'b0}};
            rptr_q   <= {PTR_W{1'b0}};
            level_q  <= ZERO_LVL;
            tready_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            tready_q <= tready_d;
            done_q   <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    // Write the accepted beat into the slot at the write pointer.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_q[wptr_q] <= {tlast, tdata};
        end
    end

    // -----------------------------------------------------------------------
    // Status counters
    // -----------------------------------------------------------------------
`ifdef AXIS_S_STATUS_EN
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q,  pkt_cnt_d;

    // Count accepted beats and accepted tlast beats; both wrap naturally.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (push_s) begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        if (push_s && tlast) begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Counter registers, cleared by the asynchronous reset.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            beat_cnt_q <= {CNT_WIDTH{1'b0}};
            pkt_cnt_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
`else
    assign beat_cnt = {CNT_WIDTH{1'b0}};
    assign pkt_cnt  = {CNT_WIDTH{1'b0}};
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Head entry is only shown while something is stored; stale array
    // contents never leak out because visibility follows the level.
    always_comb begin
        rd_data = {DATA_WIDTH{1'b0}};
        rd_last = 1'b0;
        if (rd_valid_s) begin
            rd_data = head_s[DATA_WIDTH-1:0];
            rd_last = head_s[DATA_WIDTH];
        end else begin
            rd_data = {DATA_WIDTH{1'b0}};
            rd_last = 1'b0;
        end
    end

    assign rd_valid = rd_valid_s;
    assign tready   = tready_q;
    assign level    = level_q;
    assign done     = done_q;

endmodule

// File: tb/tb_axis_s.sv
// ---------------------------------------------------------------------------
// tb_axis_s : directed self-checking bench for axis_s (DEPTH=4, CNT_WIDTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_axis_s;

    logic        aclk;
    logic        areset_n;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_en;
    logic [2:0]  level;
    logic        done;
    logic [3:0]  beat_cnt;
    logic [3:0]  pkt_cnt;

    int vec_cnt;
    int err_cnt;

    axis_s #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .CNT_WIDTH  (4)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .tvalid   (tvalid),
        .tready   (tready),
        .tdata    (tdata),
        .tlast    (tlast),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .rd_en    (rd_en),
        .level    (level),
        .done     (done),
        .beat_cnt (beat_cnt),
        .pkt_cnt  (pkt_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Expected counter value: real count modulo 16 when counters are built.
    function automatic logic [63:0] cexp(input int n);
`ifdef AXIS_S_STATUS_EN
        return 64'(n % 16);
`else
        return 64'(n - n);
`endif
    endfunction

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        areset_n = 1'b0;
        tvalid   = 1'b1;
        tdata    = 32'hDEADBEEF;
        tlast    = 1'b0;
        rd_en    = 1'b0;

        // Reset held with a beat offered
        tick();
        tick();
        chk("rst_tready",   64'(tready),   64'd0);
        chk("rst_level",    64'(level),    64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data",  64'(rd_data),  64'd0);
        chk("rst_rd_last",  64'(rd_last),  64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
        tvalid   = 1'b0;
        areset_n = 1'b1;
        tick();
        chk("post_rst_tready", 64'(tready), 64'd1);
        chk("post_rst_level",  64'(level),  64'd0);

        // Single beat with tlast
        tvalid = 1'b1; tdata = 32'h12345678; tlast = 1'b1;
        tick();
        tvalid = 1'b0; tlast = 1'b0;
        chk("single_rd_valid", 64'(rd_valid), 64'd1);
        chk("single_rd_data",  64'(rd_data),  64'h12345678);
        chk("single_rd_last",  64'(rd_last),  64'd1);
        chk("single_done",     64'(done),     64'd1);
        chk("single_level",    64'(level),    64'd1);
        chk("single_beat_cnt", 64'(beat_cnt), cexp(1));
        chk("single_pkt_cnt",  64'(pkt_cnt),  cexp(1));
        tick();
        chk("single_done_drop", 64'(done),     64'd0);
        chk("single_hold",      64'(rd_valid), 64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("single_pop_valid", 64'(rd_valid), 64'd0);
        chk("single_pop_data",  64'(rd_data),  64'd0);
        chk("single_pop_last",  64'(rd_last),  64'd0);

        // Fill to full, beat 5 held off
        tvalid = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            tdata = 32'(v);
            tick();
            chk("fill_level", 64'(level), 64'(v));
        end
        chk("full_tready", 64'(tready),  64'd0);
        chk("full_head",   64'(rd_data), 64'd1);
        tdata = 32'd5;
        tick();
        tick();
        chk("full_hold_level", 64'(level),   64'd4);
        chk("full_hold_head",  64'(rd_data), 64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pop1_tready", 64'(tready),  64'd1);
        chk("pop1_level",  64'(level),   64'd3);
        chk("pop1_head",   64'(rd_data), 64'd2);
        tick();
        tvalid = 1'b0;
        chk("beat5_level",  64'(level),  64'd4);
        chk("beat5_tready", 64'(tready), 64'd0);
        rd_en = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            chk("drain_data", 64'(rd_data), 64'(v));
            tick();
        end
        rd_en = 1'b0;
        chk("drain_level",  64'(level),  64'd0);
        chk("drain_tready", 64'(tready), 64'd1);

        // Simultaneous push/pop at level 2
        tvalid = 1'b1;
        tdata = 32'd10; tick();
        tdata = 32'd11; tick();
        chk("pp_start_level", 64'(level), 64'd2);
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tdata = 32'(12 + i);
            chk("pp_data", 64'(rd_data), 64'(10 + i));
            tick();
            chk("pp_level",  64'(level),  64'd2);
            chk("pp_tready", 64'(tready), 64'd1);
        end
        tvalid = 1'b0;
        chk("pp_tail0", 64'(rd_data), 64'd20);
        tick();
        chk("pp_tail1", 64'(rd_data), 64'd21);
        tick();
        rd_en = 1'b0;
        chk("pp_empty", 64'(level), 64'd0);

        // Empty boundary: pop request while pushing into an empty FIFO
        tvalid = 1'b1; tdata = 32'hA5A5A5A5; rd_en = 1'b1;
        chk("eb_pre_valid", 64'(rd_valid), 64'd0);
        tick();
        tvalid = 1'b0; rd_en = 1'b0;
        chk("eb_level", 64'(level),    64'd1);
        chk("eb_data",  64'(rd_data),  64'hA5A5A5A5);
        chk("eb_valid", 64'(rd_valid), 64'd1);
        chk("eb_beat_cnt", 64'(beat_cnt), cexp(19));
        chk("eb_pkt_cnt",  64'(pkt_cnt),  cexp(1));

        // Reset asserted mid-stream discards everything at once
        tvalid = 1'b1; tdata = 32'd77;
        tick();
        tvalid = 1'b0;
        #2;
        areset_n = 1'b0;
        #1;
        chk("mid_rst_tready", 64'(tready),   64'd0);
        chk("mid_rst_level",  64'(level),    64'd0);
        chk("mid_rst_valid",  64'(rd_valid), 64'd0);
        chk("mid_rst_data",   64'(rd_data),  64'd0);
        chk("mid_rst_cnt",    64'(beat_cnt), 64'd0);
        tick();
        areset_n = 1'b1;
        tick();
        chk("mid_rst_ready_back", 64'(tready), 64'd1);

        // Counters: 17 beats, tlast on every 4th, popping alongside
        rd_en  = 1'b1;
        tvalid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tdata = 32'(100 + i);
            tlast = ((i % 4) == 3);
            tick();
            chk("cnt_done", 64'(done), 64'(((i % 4) == 3) ? 1 : 0));
        end
        tvalid = 1'b0; tlast = 1'b0; rd_en = 1'b0;
        chk("cnt_level",    64'(level),    64'd1);
        chk("cnt_head",     64'(rd_data),  64'd116);
        chk("cnt_beat_cnt", 64'(beat_cnt), cexp(17));
        chk("cnt_pkt_cnt",  64'(pkt_cnt),  cexp(4));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
